// File: rtl/wb_arbiter2.sv
// wb_arbiter2: two-master round-robin Wishbone B4 pipelined arbiter with outstanding-request limiting.
// Optional slave watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_arbiter2 #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES = 255
)(
  input  logic            clk,
  input  logic            rst,
  input  logic            m0_cyc,
  input  logic            m0_stb,
  input  logic            m0_we,
  input  logic [DW/8-1:0] m0_sel,
  input  logic [AW-1:0]   m0_adr,
  input  logic [DW-1:0]   m0_wdat,
  output logic [DW-1:0]   m0_rdat,
  output logic            m0_ack,
  output logic            m0_err,
  output logic            m0_stall,
  input  logic            m1_cyc,
  input  logic            m1_stb,
  input  logic            m1_we,
  input  logic [DW/8-1:0] m1_sel,
  input  logic [AW-1:0]   m1_adr,
  input  logic [DW-1:0]   m1_wdat,
  output logic [DW-1:0]   m1_rdat,
  output logic            m1_ack,
  output logic            m1_err,
  output logic            m1_stall,
  output logic            s_cyc,
  output logic            s_stb,
  output logic            s_we,
  output logic [DW/8-1:0] s_sel,
  output logic [AW-1:0]   s_adr,
  output logic [DW-1:0]   s_wdat,
  input  logic [DW-1:0]   s_rdat,
  input  logic            s_ack,
  input  logic            s_err,
  input  logic            s_stall
);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;
  state_t state, state_n;
  logic last, last_n;
  logic [CW-1:0] cnt, cnt_n;
  logic g0, g1, room, rsp_ok, inc, dec, to;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      last  <= 1'b1;
      cnt   <= '0;
    end else begin
      state <= state_n;
      last  <= last_n;
      cnt   <= cnt_n;
    end

  always_comb begin
    state_n = state;
    last_n  = last;
    cnt_n   = to ? '0 : cnt + CW'(inc) - CW'(dec);
    if (state == IDLE) begin
      cnt_n = '0;
      if (m0_cyc & (!m1_cyc | last)) state_n = GNT0;
      else if (m1_cyc) state_n = GNT1;
    end else if (!s_cyc) begin
      state_n = IDLE;
      last_n  = g1;
      cnt_n   = '0;
    end
  end

  // Responses only count while requests are outstanding, so late acks after an abort or timeout are dropped.
  always_comb begin
    g0       = state == GNT0;
    g1       = state == GNT1;
    room     = cnt < CW'(MAX_OUTSTANDING);
    rsp_ok   = (g0 | g1) & (cnt != '0);
    s_cyc    = g0 ? m0_cyc : g1 & m1_cyc;
    s_we     = g0 ? m0_we : g1 & m1_we;
    s_sel    = g0 ? m0_sel : g1 ? m1_sel : '0;
    s_adr    = g0 ? m0_adr : g1 ? m1_adr : '0;
    s_wdat   = g0 ? m0_wdat : g1 ? m1_wdat : '0;
    s_stb    = s_cyc & (g0 ? m0_stb : m1_stb) & room;
    inc      = s_stb & !s_stall;
    dec      = rsp_ok & (s_ack | s_err);
    m0_stall = !g0 | s_stall | !room;
    m1_stall = !g1 | s_stall | !room;
    m0_ack   = g0 & rsp_ok & s_ack;
    m1_ack   = g1 & rsp_ok & s_ack;
    m0_err   = g0 & (rsp_ok & s_err | to);
    m1_err   = g1 & (rsp_ok & s_err | to);
    m0_rdat  = g0 ? s_rdat : '0;
    m1_rdat  = g1 ? s_rdat : '0;
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wdt;
  logic idle_wdt;
  assign idle_wdt = (state == IDLE) | (cnt == '0) | s_ack | s_err;
  assign to = !idle_wdt & (wdt == TW'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge clk or posedge rst)
    if (rst) wdt <= '0;
    else wdt <= (idle_wdt | to) ? '0 : wdt + 1'b1;
`else
  assign to = TIMEOUT_CYCLES < 0;
`endif
endmodule
